// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Request struct widths are fixed here; the top parameters default to the same values.
package mem_port_arbiter_pkg;

    localparam int unsigned MEM_ADDR_W = 64;
    localparam int unsigned MEM_DATA_W = 64;
    localparam int unsigned MEM_STRB_W = MEM_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } arb_owner_t;

    typedef enum logic [2:0] {
        MSIZE1 = 3'd0,
        MSIZE2 = 3'd1,
        MSIZE4 = 3'd2,
        MSIZE8 = 3'd3
    } msize_t;

    typedef struct packed {
        logic                  is_write;
        msize_t                size;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_STRB_W-1:0] strobe;
        logic [MEM_DATA_W-1:0] data;
    } mem_req_t;

    // A fetch is always a 32-bit read at the given address.
    function automatic mem_req_t make_fetch_req(input logic [MEM_ADDR_W-1:0] addr);
        mem_req_t r;
        r          = '0;
        r.size     = MSIZE4;
        r.addr     = addr;
        return r;
    endfunction

endpackage

// File: rtl/mem_req_latch.sv
// Holds the granted request stable for the downstream port until the transaction ends.
module mem_req_latch
    import mem_port_arbiter_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     load_i,
    input  mem_req_t req_i,
    output mem_req_t req_o
);

    mem_req_t req_d, req_q;

    always_comb begin
        req_d = req_q;
        if (load_i) begin
            req_d = req_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q <= '0;
        end else begin
            req_q <= req_d;
        end
    end

    assign req_o = req_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-beat memory port between the fetch and data buses.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed dbus > ibus priority.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_W,
    parameter int unsigned DATA_W = MEM_DATA_W
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ireq_valid,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              iresp_addr_ok,
    output logic              iresp_data_ok,
    output logic [31:0]       iresp_data,

    input  logic              dreq_valid,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [2:0]        dreq_size,
    input  logic [7:0]        dreq_strobe,
    input  logic [DATA_W-1:0] dreq_data,
    output logic              dresp_addr_ok,
    output logic              dresp_data_ok,
    output logic [DATA_W-1:0] dresp_data,

    output logic              oreq_valid,
    output logic              oreq_is_write,
    output logic [ADDR_W-1:0] oreq_addr,
    output logic [2:0]        oreq_size,
    output logic [7:0]        oreq_strobe,
    output logic [DATA_W-1:0] oreq_data,
    input  logic              oresp_ready,
    input  logic [DATA_W-1:0] oresp_data
);

    arb_state_t state_d, state_q;
    logic       oreq_valid_d, oreq_valid_q;
    logic       load;
    logic       pick_d;
    mem_req_t   req_d, req_q;
    mem_req_t   fetch_req, data_req;
    logic       i_done, d_done;

`ifdef MEM_ARB_RR_EN
    arb_owner_t last_owner_d, last_owner_q;
`endif

    always_comb begin
        fetch_req         = make_fetch_req(ireq_addr);
        data_req          = '0;
        data_req.is_write = |dreq_strobe;
        data_req.size     = msize_t'(dreq_size);
        data_req.addr     = dreq_addr;
        data_req.strobe   = dreq_strobe;
        data_req.data     = dreq_data;
    end

    // Data side wins unless round-robin says the fetch side is due.
`ifdef MEM_ARB_RR_EN
    assign pick_d = dreq_valid && (!ireq_valid || (last_owner_q == OWN_I));
`else
    assign pick_d = dreq_valid;
`endif

    always_comb begin
        state_d      = state_q;
        oreq_valid_d = oreq_valid_q;
        load         = 1'b0;
        req_d        = fetch_req;
`ifdef MEM_ARB_RR_EN
        last_owner_d = last_owner_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_d) begin
                    load         = 1'b1;
                    req_d        = data_req;
                    state_d      = BUSY_D;
                    oreq_valid_d = 1'b1;
`ifdef MEM_ARB_RR_EN
                    last_owner_d = OWN_D;
`endif
                end else if (ireq_valid) begin
                    load         = 1'b1;
                    req_d        = fetch_req;
                    state_d      = BUSY_I;
                    oreq_valid_d = 1'b1;
`ifdef MEM_ARB_RR_EN
                    last_owner_d = OWN_I;
`endif
                end
            end
            BUSY_I, BUSY_D: begin
                // Completion always returns to IDLE, giving one bubble before the next grant.
                if (oresp_ready) begin
                    state_d      = IDLE;
                    oreq_valid_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                oreq_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            oreq_valid_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= OWN_I;
`endif
        end else begin
            state_q      <= state_d;
            oreq_valid_q <= oreq_valid_d;
`ifdef MEM_ARB_RR_EN
            last_owner_q <= last_owner_d;
`endif
        end
    end

    mem_req_latch u_req_latch (
        .clk_i  (clk),
        .rst_i  (reset),
        .load_i (load),
        .req_i  (req_d),
        .req_o  (req_q)
    );

    assign oreq_valid    = oreq_valid_q;
    assign oreq_is_write = req_q.is_write;
    assign oreq_addr     = req_q.addr;
    assign oreq_size     = req_q.size;
    assign oreq_strobe   = req_q.strobe;
    assign oreq_data     = req_q.data;

    assign i_done = (state_q == BUSY_I) && oresp_ready;
    assign d_done = (state_q == BUSY_D) && oresp_ready;

    assign iresp_addr_ok = i_done;
    assign iresp_data_ok = i_done;
    assign iresp_data    = !i_done    ? 32'h0 :
                           req_q.addr[2] ? oresp_data[63:32] : oresp_data[31:0];

    assign dresp_addr_ok = d_done;
    assign dresp_data_ok = d_done;
    assign dresp_data    = d_done ? oresp_data : '0;

endmodule
